// File: rtl/sram_spi_master.sv
// Mode-0 SPI master that issues single-byte 23A640 SRAM read/write frames.
// The sck half-period is CLK_DIV system clocks; all outputs are registered.
module sram_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic        csb_o,
  output logic        sck_o,
  output logic        si_o,
  input  logic        so_i
);

  localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLo,
    StShiftHi,
    StHold,
    StGap,
    StFin
  } state_e;

  state_e      state_q;
  logic [31:0] frame_q;
  logic [7:0]  rx_q;
  logic [7:0]  rdata_q;
  logic [5:0]  bit_q;
  logic [7:0]  div_q;
  logic        we_q;
  logic        busy_q;
  logic        done_q;
  logic        csb_q;
  logic        sck_q;
  logic        si_q;
  logic        div_last;

  assign div_last = (div_q == DivMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      frame_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
      sck_q   <= 1'b0;
      si_q    <= 1'b0;
    end else begin
      if (state_q != StIdle) begin
        div_q <= div_last ? 8'd0 : div_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (req_i) begin
            frame_q <= {(we_i ? 8'h02 : 8'h03), addr_i, (we_i ? wdata_i : 8'h00)};
            we_q    <= we_i;
            bit_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b1;
            csb_q   <= 1'b0;
            // Both opcodes have a zero MSB, so the first si bit is known here.
            si_q    <= 1'b0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (div_last) state_q <= StShiftLo;
        end
        StShiftLo: begin
          if (div_last) begin
            sck_q   <= 1'b1;
            state_q <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (div_last) begin
            rx_q    <= {rx_q[6:0], so_i};
            frame_q <= {frame_q[30:0], 1'b0};
            bit_q   <= bit_q + 6'd1;
            sck_q   <= 1'b0;
            // si moves together with the falling sck edge, never while sck is high.
            if (bit_q == 6'd31) begin
              si_q    <= 1'b0;
              state_q <= StHold;
            end else begin
              si_q    <= frame_q[30];
              state_q <= StShiftLo;
            end
          end
        end
        StHold: begin
          if (div_last) begin
            csb_q   <= 1'b1;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (div_last) begin
            done_q  <= 1'b1;
            if (!we_q) rdata_q <= rx_q;
            state_q <= StFin;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign csb_o   = csb_q;
  assign sck_o   = sck_q;
  assign si_o    = si_q;

endmodule

// File: tb/tb_sram_spi_master.sv
// Scoreboard bench for sram_spi_master with CLK_DIV=4 and CLK_DIV=1 instances,
// an SRAM slave model per instance and a continuous mode-0 protocol checker.
module tb_sram_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, req, we, busy, done, csb, sck, si;
  logic [15:0] addr [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic [7:0]  slave_byte [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc [2];

  // Hand-computed timing per instance: index 0 is CLK_DIV=4, index 1 is CLK_DIV=1.
  int exp_low   [2] = '{264, 66};
  int exp_done  [2] = '{269, 68};
  int exp_first [2] = '{8, 2};
  int exp_per   [2] = '{8, 2};

  typedef struct {
    int          inst;
    logic [31:0] frame;
  } frame_t;

  typedef struct {
    int         inst;
    logic [7:0] rd;
  } done_t;

  frame_t fq[$];
  done_t  dq[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned Div = (g == 0) ? 4 : 1;
    logic        so = 1'b0;
    logic [31:0] sh = '0;
    int          pulses = 0;
    int          t_fall = 0;
    int          t_rise = 0;
    int          first_off = 0;
    int          pmin = 0;
    int          pmax = 0;
    int          t_rise_csb = 0;
    int          gap = 0;
    bit          busy_chk = 1'b0;
    logic        prev_si, prev_sck, prev_csb;

    sram_spi_master #(.CLK_DIV(Div)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n[g]),
      .req_i   (req[g]),
      .we_i    (we[g]),
      .addr_i  (addr[g]),
      .wdata_i (wdata[g]),
      .busy_o  (busy[g]),
      .done_o  (done[g]),
      .rdata_o (rdata[g]),
      .csb_o   (csb[g]),
      .sck_o   (sck[g]),
      .si_o    (si[g]),
      .so_i    (so)
    );

    always @(negedge csb[g]) begin
      sh = '0;
      pulses = 0;
      t_fall = cyc;
      pmin = 1000;
      pmax = 0;
      gap = cyc - t_rise_csb;
    end

    always @(posedge sck[g]) begin
      if (!csb[g]) begin
        sh = {sh[30:0], si[g]};
        pulses++;
        if (pulses == 1) begin
          first_off = cyc - t_fall;
        end else begin
          if (cyc - t_rise < pmin) pmin = cyc - t_rise;
          if (cyc - t_rise > pmax) pmax = cyc - t_rise;
        end
        t_rise = cyc;
      end
    end

    // Slave presents read data bit by bit on the falling edges after the address.
    always @(negedge sck[g]) begin
      if (!csb[g] && pulses >= 24 && pulses <= 31) so = slave_byte[g][31 - pulses];
    end

    always @(posedge csb[g]) begin
      frame_t e;
      if (rst_n[g]) begin
        t_rise_csb = cyc;
        if (fq.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = fq.pop_front();
          chk("frame_inst", 32'(g), 32'(e.inst));
          chk("si_frame", sh, e.frame);
          chk("sck_pulses", 32'(pulses), 32'd32);
          chk("csb_low_cycles", 32'(cyc - t_fall), 32'(exp_low[g]));
          chk("first_sck_offset", 32'(first_off), 32'(exp_first[g]));
          chk("sck_period_min", 32'(pmin), 32'(exp_per[g]));
          chk("sck_period_max", 32'(pmax), 32'(exp_per[g]));
        end
      end
    end

    always @(posedge clk) begin
      done_t d;
      #1;
      if (busy_chk) begin
        chk("busy_after_done", 32'(busy[g]), 32'd0);
        busy_chk = 1'b0;
      end
      if (done[g] === 1'b1) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          d = dq.pop_front();
          chk("done_inst", 32'(g), 32'(d.inst));
          chk("rdata_at_done", 32'(rdata[g]), 32'(d.rd));
          chk("done_cycle", 32'(cyc - acc_cyc[g] + 1), 32'(exp_done[g]));
          chk("busy_at_done", 32'(busy[g]), 32'd1);
          busy_chk = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (rst_n[g]) begin
        if (si[g] !== prev_si) chk("si_change_sck_low", 32'(sck[g]), 32'd0);
        if (csb[g] !== prev_csb) chk("csb_change_sck_low", 32'({prev_sck, sck[g]}), 32'd0);
      end
      prev_si  = si[g];
      prev_sck = sck[g];
      prev_csb = csb[g];
    end
  end

  task automatic issue(input int i, input bit w, input logic [15:0] a, input logic [7:0] wd,
                       input logic [7:0] sb, input bit track, input logic [31:0] ef,
                       input logic [7:0] er);
    slave_byte[i] = sb;
    if (track) begin
      fq.push_back(frame_t'{i, ef});
      dq.push_back(done_t'{i, er});
    end
    @(posedge clk);
    #1;
    req[i] = 1'b1;
    we[i] = w;
    addr[i] = a;
    wdata[i] = wd;
    @(posedge clk);
    #1;
    acc_cyc[i] = cyc;
    req[i] = 1'b0;
    we[i] = ~w;
    addr[i] = ~a;
    wdata[i] = ~wd;
    chk("busy_after_accept", 32'(busy[i]), 32'd1);
    chk("csb_after_accept", 32'(csb[i]), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (dq.size() != 0 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (dq.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      dq.delete();
      fq.delete();
    end
  endtask

  task automatic poke(input int i, input int wait_cycles);
    repeat (wait_cycles) @(posedge clk);
    #1;
    req[i] = 1'b1;
    we[i] = 1'b0;
    addr[i] = 16'h0000;
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int i);
    chk("rst_csb", 32'(csb[i]), 32'd1);
    chk("rst_sck", 32'(sck[i]), 32'd0);
    chk("rst_si", 32'(si[i]), 32'd0);
    chk("rst_busy", 32'(busy[i]), 32'd0);
    chk("rst_done", 32'(done[i]), 32'd0);
    chk("rst_rdata", 32'(rdata[i]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 2'b00;
    req = 2'b00;
    we = 2'b00;
    addr = '{16'h0, 16'h0};
    wdata = '{8'h0, 8'h0};
    slave_byte = '{8'h0, 8'h0};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_n = 2'b11;

    // CLK_DIV=4: write, read, then write that must leave rdata untouched.
    issue(0, 1'b1, 16'h01AA, 8'hAB, 8'h00, 1'b1, 32'h0201AAAB, 8'h00);
    wait_done();
    issue(0, 1'b0, 16'h01AA, 8'h77, 8'h5C, 1'b1, 32'h0301AA00, 8'h5C);
    wait_done();
    issue(0, 1'b1, 16'hFFFF, 8'h81, 8'hE7, 1'b1, 32'h02FFFF81, 8'h5C);
    wait_done();

    // CLK_DIV=1 reads.
    issue(1, 1'b0, 16'h01AA, 8'h00, 8'h5C, 1'b1, 32'h0301AA00, 8'h5C);
    wait_done();
    issue(1, 1'b0, 16'h8000, 8'hFF, 8'h3A, 1'b1, 32'h03800000, 8'h3A);
    wait_done();

    // Requests during a frame are ignored; a request right after done is accepted.
    issue(0, 1'b1, 16'h0F0F, 8'h55, 8'h00, 1'b1, 32'h020F0F55, 8'h5C);
    poke(0, 8);
    poke(0, 89);
    wait_done();
    issue(0, 1'b0, 16'h0102, 8'h00, 8'hC3, 1'b1, 32'h03010200, 8'hC3);
    chk("csb_gap_back_to_back", 32'(g_inst[0].gap), 32'd6);
    wait_done();

    // Reset during bit 15 aborts the frame and clears rdata.
    issue(0, 1'b0, 16'h0F0F, 8'h00, 8'hFF, 1'b0, 32'h0, 8'h00);
    n = 0;
    while (!(g_inst[0].pulses == 16 && sck[0] === 1'b1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("bit15_timeout", 32'd1, 32'd0);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check_reset_outputs(0);
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_in_reset", 32'(done[0]), 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    issue(0, 1'b1, 16'h0ABC, 8'h3C, 8'h00, 1'b1, 32'h020ABC3C, 8'h00);
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    chk("frame_queue_empty", 32'(fq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_spi_master.md
# sram_spi_master

SPI master that sits directly upstream of the 23A640 SRAM SPI slave interface. It turns one-cycle host requests (single-byte read or write at a 16-bit address) into a complete mode-0 SPI frame on `csb`/`sck`/`si`, and captures read data from `so`. `sck` is derived from the system clock by a programmable divider.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period; legal range 1..255.

Ports:
- `clk` input 1: system clock; all logic runs on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input 1: start-transaction strobe; sampled only in IDLE.
- `we` input 1: 1 = write (instruction 0x02), 0 = read (instruction 0x03); latched with `req`.
- `addr` input 16: SRAM byte address; latched with `req`.
- `wdata` input 8: write byte; latched with `req`; ignored for reads.
- `busy` output 1: high from the cycle after acceptance through the cycle `done` is high.
- `done` output 1: one-cycle pulse at transaction end.
- `rdata` output 8: read byte; updated only at the end of a read, otherwise holds its value.
- `csb` output 1: SPI chip select, active low.
- `sck` output 1: SPI clock, idles low (mode 0).
- `si` output 1: SPI data to slave, MSB first.
- `so` input 1: SPI data from slave.

## Operation
- Reset values: `csb`=1, `sck`=0, `si`=0, `busy`=0, `done`=0, `rdata`=0x00; FSM in IDLE.
- 32-bit frame shift register = {instr[7:0], addr[15:0], data[7:0]}. Data byte = `wdata` for writes and 0x00 for reads.
- A 6-bit bit counter tracks 0..31. A divider counter counts 0..CLK_DIV-1.
- FSM states:
  - IDLE: `csb`=1, `sck`=0. If `req`=1, latch the frame and go to SETUP.
  - SETUP: `csb`=0, `sck`=0, `si`=frame[31]. Lasts CLK_DIV cycles, then goes to SHIFT_LO.
  - SHIFT_LO: `sck`=0, `si`=current MSB. Lasts CLK_DIV cycles, then goes to SHIFT_HI.
  - SHIFT_HI: `sck`=1. On the final cycle of the phase:
    - shift `so` into the 8-bit receive register;
    - shift the frame left by one;
    - increment the bit counter.
    - Exit: to SHIFT_LO if count < 31, or to HOLD after bit 31.
  - HOLD: `sck`=0, `csb`=0, `si`=0. Lasts CLK_DIV cycles.
  - GAP: `csb`=1. Lasts CLK_DIV cycles (minimum deselect time). Then go to FIN.
  - FIN: `done`=1 for one cycle. If a read, `rdata` ← receive register (the last 8 sampled bits). Return to IDLE.
- `si` changes only while `sck` is low. The slave samples `si` on the rising edge of `sck`.
- `so` is sampled while `sck` is high, just before the falling edge. The slave drives `so` on the falling edge.
- `req` while `busy` is ignored; no queueing.
- `we`/`addr`/`wdata` may change freely after acceptance.
- Reset asserted mid-frame:
  - all outputs return to reset values immediately (`csb` rises asynchronously);
  - the partial frame is discarded and `done` is not pulsed;
  - `rdata` clears to 0x00.

## Timing
- Acceptance edge = the edge where `req` is sampled in IDLE. `busy` rises on that edge.
- `csb` falls on the acceptance edge. First `sck` rise occurs 2·CLK_DIV cycles later.
- `sck` period = 2·CLK_DIV cycles, 50% duty, 32 pulses per frame.
- `csb` rises (3+64)·CLK_DIV − CLK_DIV = 66·CLK_DIV cycles after falling.
  - Breakdown: SETUP CLK_DIV + shift 64·CLK_DIV + HOLD CLK_DIV.
- `done` is high in cycle 67·CLK_DIV+1 after acceptance. `rdata` is valid in the same cycle.
- `busy` falls in the cycle after `done`. A `req` present in that cycle is accepted; back-to-back frames are separated by ≥ CLK_DIV+2 cycles of `csb` high.

## Test plan
- Write `addr`=0x01AA, `wdata`=0xAB, CLK_DIV=4:
  - `si` captured on `sck` rises = 0x0201AAAB, MSB first, exactly 32 pulses;
  - `done` at cycle 269; `rdata` unchanged.
- Read `addr`=0x01AA with the slave model driving 0x5C on the last 8 falling edges:
  - `si` = 0x0301AA00;
  - `rdata`=0x5C when `done`=1.
- CLK_DIV=1:
  - `sck` period 2 cycles, `csb` low for 66 cycles, `done` at cycle 68;
  - repeat the read and check `rdata` is correct.
- `req` pulsed at cycles 10 and 100 of an active frame: ignored, exactly one `done`. Then `req` in the cycle after `done` starts a new frame.
- `rst` asserted low during bit 15:
  - `csb`=1, `sck`=0, `busy`=0 immediately;
  - no `done`, `rdata`=0x00.
  - After release, a fresh write completes normally.
- Protocol checker throughout all scenarios:
  - `si` never changes while `sck`=1;
  - `sck` is 0 whenever `csb` transitions.
